// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with a per-register busy
// scoreboard, optional writeback-to-read bypass and a post-reset zeroing
// sweep. The storage array has no reset; the sweep clears entries 1..NREG-1
// and entry 0 is never read (index 0 always returns zero).
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_INIT | zeroing sweep, one entry per cycle; inputs ignored, reads 0
// ST_RUN  | normal operation: writeback, issue/flush scoreboard, reads
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 3,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  init_done_o,
    input  logic                  wb_en_i,
    input  logic [AW-1:0]         wb_idx_i,
    input  logic [XLEN-1:0]       wb_data_i,
    input  logic                  iss_en_i,
    input  logic [AW-1:0]         iss_idx_i,
    input  logic                  flush_i,
    input  logic [NRD-1:0]        rd_en_i,
    input  logic [NRD*AW-1:0]     rd_idx_i,
    output logic [NRD*XLEN-1:0]   rd_data_o,
    output logic [NRD-1:0]        rd_busy_o
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [XLEN-1:0]   mem_q [NREG];

    logic              mem_we;
    logic [AW-1:0]     mem_widx;
    logic [XLEN-1:0]   mem_wdata;
    logic [AW-1:0]     rd_idx [NRD];

    for (genvar g = 0; g < NRD; g++) begin : g_idx
        assign rd_idx[g] = rd_idx_i[g*AW +: AW];
    end

    // State, sweep counter and scoreboard registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            cnt_q   <= AW'(1);
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: leave the sweep once the last entry has been written
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (cnt_q == AW'(NREG - 1)) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Outputs of the FSM: storage write port selection and done flag
    always_comb begin
        init_done_o = (state_q == ST_RUN);
        mem_we      = 1'b0;
        mem_widx    = wb_idx_i;
        mem_wdata   = wb_data_i;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_widx  = cnt_q;
            mem_wdata = '0;
        end else begin
            mem_we    = wb_en_i && (wb_idx_i != '0);
        end
    end

    // Sweep counter advance and scoreboard update (issue wins over flush/wb)
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + AW'(1);
        end else begin
            if (flush_i)
                busy_d = '0;
            else if (wb_en_i)
                busy_d[wb_idx_i] = 1'b0;
            if (iss_en_i && (iss_idx_i != '0))
                busy_d[iss_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Storage array, deliberately without reset
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_widx] <= mem_wdata;
    end

    // Combinational read ports with optional same-cycle writeback forwarding
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NRD; p++) begin
            if ((state_q == ST_RUN) && rd_en_i[p] && (rd_idx[p] != '0)) begin
                if ((BYPASS != 0) && wb_en_i && (wb_idx_i == rd_idx[p])) begin
                    rd_data_o[p*XLEN +: XLEN] = wb_data_i;
                end else begin
                    rd_data_o[p*XLEN +: XLEN] = mem_q[rd_idx[p]];
                    rd_busy_o[p]              = busy_q[rd_idx[p]];
                end
            end
        end
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with configurable depth, width and read-port count. It adds a per-register busy scoreboard, optional same-cycle write-to-read bypass, and a post-reset initialisation sweep, so the storage array itself needs no reset. It sits between decode/issue (read ports, busy marking) and writeback (single write port), and replaces the fixed three-read-port file in the pipelined core.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; power of 2, at least 4; index 0 is hardwired zero
- NRD, 3, number of independent read ports
- BYPASS, 1, 1 = writeback data is forwarded combinationally to reads of the same index; 0 = no forwarding
- AW, log2(NREG), localparam, index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- init_done_o  out  1  high once the zeroing sweep has finished; low throughout reset and the sweep
- wb_en_i  in  1  writeback write enable
- wb_idx_i  in  AW  writeback register index
- wb_data_i  in  XLEN  writeback data
- iss_en_i  in  1  issue: marks iss_idx_i busy (pending producer)
- iss_idx_i  in  AW  index of destination being issued
- flush_i  in  1  clears every busy bit (pipeline squash)
- rd_en_i  in  NRD  per-port read enable
- rd_idx_i  in  NRD*AW  port p index at [p*AW +: AW]
- rd_data_o  out  NRD*XLEN  port p data at [p*XLEN +: XLEN]
- rd_busy_o  out  NRD  port p: register has an outstanding producer

## Operation
- States: INIT, RUN. Reset forces INIT, sweep counter = 1, all busy bits = 0, init_done_o = 0.
- INIT: each cycle writes zero to entry[counter], then counter++. After entry NREG-1 is written, go to RUN and set init_done_o = 1. wb_en_i, iss_en_i and flush_i are ignored. All rd_data_o = 0 and rd_busy_o = 0.
- RUN write: if wb_en_i and wb_idx_i != 0, entry[wb_idx_i] <= wb_data_i. Writes to index 0 are dropped.
- Busy update, in priority order per bit:
  - if flush_i, clear all;
  - otherwise, if wb_en_i, clear busy[wb_idx_i];
  - then, if iss_en_i and iss_idx_i != 0, set busy[iss_idx_i]. Issue overrides both flush and writeback, so a new producer issued in the same cycle stays pending.
  - busy[0] is always 0.
- Read port p, combinational:
  - if !rd_en_i[p] or idx == 0, data = 0 and busy = 0;
  - else if BYPASS and wb_en_i and wb_idx_i == idx, data = wb_data_i and busy = 0;
  - else data = entry[idx] and busy = busy[idx].
- Ports are fully independent. Any number may read the same index simultaneously.
- A reset assertion mid-RUN or mid-INIT immediately returns the block to INIT and restarts the sweep from 1. Storage contents are not guaranteed until init_done_o is high again.

## Timing
- Reset values: init_done_o = 0, rd_data_o = 0, rd_busy_o = 0, busy vector = 0, counter = 1.
- Sweep length: exactly NREG-1 cycles after the first rising edge with reset_n high. init_done_o is high from the edge that writes entry NREG-1 (31 edges for NREG = 32).
- Write latency: data is visible on reads in the cycle after the write edge. With BYPASS = 1 it is also visible combinationally in the write cycle itself.
- Busy latency: set or clear takes effect at the edge and is visible in the next cycle. BYPASS masks the busy flag only in the writeback cycle.
- Read path is combinational from rd_idx_i, rd_en_i and the wb_* inputs. There is no registered output stage.

## Test plan
- Reset, NREG=32: release reset_n, then count edges → init_done_o rises after exactly 31 edges. A port-0 read of x7 afterwards returns 0x00000000.
- Write and read: write x5 = 0xDEADBEEF, read x5 on all 3 ports the next cycle → all return 0xDEADBEEF. Write x0 = 0x12345678, then read x0 → 0.
- Bypass: BYPASS=1, write x9 = 0xCAFEF00D while port 1 reads x9 in the same cycle → port 1 returns 0xCAFEF00D with busy 0. With BYPASS=0 the same stimulus returns the old value (0).
- Scoreboard: issue x3 → rd_busy_o for x3 is 1 next cycle. Writeback x3 together with a simultaneous issue of x3 → busy stays 1. Writeback alone → busy becomes 0.
- Flush: issue x4 and x6, then assert flush_i together with an issue of x6 → next cycle x4 busy = 0 and x6 busy = 1.
- Reset mid-operation: drop reset_n while x5 = 0xDEADBEEF in RUN → init_done_o = 0 and all rd_busy_o = 0 immediately. After 31 edges, x5 reads 0.
